// File: rtl/alu_op_sequencer.sv
// Sequencer that owns a shared combinational ALU: single ops issue once, MUL is
// run as an iterative shift-add that reuses the ALU adder one step per cycle.
module alu_op_sequencer #(
  parameter int XLEN       = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            resp_zero,
  output logic            resp_err,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;

  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

  state_t          state_q;
  logic            req_ready_q, resp_valid_q, resp_zero_q, resp_err_q;
  logic [XLEN-1:0] resp_result_q;
  // In MUL the ALU operand registers double as accumulator and multiplicand.
  logic [XLEN-1:0] alu_a_q, alu_b_q;
  logic [3:0]      alu_ctrl_q;
  logic [XLEN-1:0] mplier_q;
  logic [CW-1:0]   cnt_q;

  logic [XLEN-1:0] acc_d, mcand_d, mplier_d;
  logic [CW-1:0]   cnt_d;
  logic            mul_last;

  function automatic logic [3:0] ctrl_of(input logic [2:0] op);
    case (op)
      3'b000:  ctrl_of = CTRL_AND;
      3'b001:  ctrl_of = CTRL_OR;
      3'b010:  ctrl_of = CTRL_ADD;
      3'b011:  ctrl_of = CTRL_SUB;
      3'b100:  ctrl_of = CTRL_SLT;
      default: ctrl_of = CTRL_AND;
    endcase
  endfunction

  always_comb begin
    acc_d    = mplier_q[0] ? alu_result : alu_a_q;
    mcand_d  = alu_b_q << 1;
    mplier_d = mplier_q >> 1;
    cnt_d    = cnt_q + 1'b1;
    mul_last = (cnt_q == CW'(XLEN-1)) || (EARLY_EXIT && (mplier_d == '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      resp_zero_q   <= 1'b0;
      resp_err_q    <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_ctrl_q    <= CTRL_AND;
      mplier_q      <= '0;
      cnt_q         <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            if (req_op < OP_MUL) begin
              alu_a_q    <= req_a;
              alu_b_q    <= req_b;
              alu_ctrl_q <= ctrl_of(req_op);
              state_q    <= S_EXEC;
            end else if (req_op == OP_MUL) begin
              alu_a_q    <= '0;
              alu_b_q    <= req_a;
              alu_ctrl_q <= CTRL_ADD;
              mplier_q   <= req_b;
              cnt_q      <= '0;
              state_q    <= S_MUL;
            end else begin
              resp_result_q <= '0;
              resp_zero_q   <= 1'b1;
              resp_err_q    <= 1'b1;
              resp_valid_q  <= 1'b1;
              state_q       <= S_DONE;
            end
          end
        end
        S_EXEC: begin
          resp_result_q <= alu_result;
          resp_zero_q   <= (alu_result == '0);
          resp_err_q    <= 1'b0;
          resp_valid_q  <= 1'b1;
          alu_a_q       <= '0;
          alu_b_q       <= '0;
          alu_ctrl_q    <= CTRL_AND;
          state_q       <= S_DONE;
        end
        S_MUL: begin
          if (mul_last) begin
            resp_result_q <= acc_d;
            resp_zero_q   <= (acc_d == '0);
            resp_err_q    <= 1'b0;
            resp_valid_q  <= 1'b1;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_ctrl_q    <= CTRL_AND;
            state_q       <= S_DONE;
          end else begin
            alu_a_q  <= acc_d;
            alu_b_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
          end
        end
        S_DONE: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign resp_zero   = resp_zero_q;
  assign resp_err    = resp_err_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_ctrl    = alu_ctrl_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (early exit on/off) against a
// transaction-level model with a per-cycle compare process.
module tb_alu_op_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  req_valid, resp_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        req_ready[2], resp_valid[2], resp_zero[2], resp_err[2];
  logic [31:0] resp_result[2], alu_a[2], alu_b[2], alu_res[2];
  logic [3:0]  alu_ctrl[2];

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] c);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_res[0] = alu_f(alu_a[0], alu_b[0], alu_ctrl[0]);
  assign alu_res[1] = alu_f(alu_a[1], alu_b[1], alu_ctrl[1]);

  alu_op_sequencer #(.XLEN(32), .EARLY_EXIT(1'b1)) u_ee (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid[0]),
    .resp_ready(resp_ready[0]), .resp_result(resp_result[0]), .resp_zero(resp_zero[0]),
    .resp_err(resp_err[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_ctrl(alu_ctrl[0]),
    .alu_result(alu_res[0]));

  alu_op_sequencer #(.XLEN(32), .EARLY_EXIT(1'b0)) u_full (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid[1]),
    .resp_ready(resp_ready[1]), .resp_result(resp_result[1]), .resp_zero(resp_zero[1]),
    .resp_err(resp_err[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_ctrl(alu_ctrl[1]),
    .alu_result(alu_res[1]));

  // Expected outputs per instance, updated by the driver just after each edge.
  logic        e_rdy[2], e_vld[2], e_zero[2], e_err[2], e_chkres[2];
  logic [31:0] e_res[2], e_aa[2], e_ab[2];
  logic [3:0]  e_ac[2];
  logic        chk_en;
  int          n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
  endtask

  task automatic set_idle(input int i);
    e_rdy[i] = 1'b1; e_vld[i] = 1'b0; e_chkres[i] = 1'b0;
    e_aa[i] = '0; e_ab[i] = '0; e_ac[i] = 4'b0000;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("d%0d req_ready", i), {31'b0, req_ready[i]}, {31'b0, e_rdy[i]});
        chk($sformatf("d%0d resp_valid", i), {31'b0, resp_valid[i]}, {31'b0, e_vld[i]});
        chk($sformatf("d%0d alu_a", i), alu_a[i], e_aa[i]);
        chk($sformatf("d%0d alu_b", i), alu_b[i], e_ab[i]);
        chk($sformatf("d%0d alu_ctrl", i), {28'b0, alu_ctrl[i]}, {28'b0, e_ac[i]});
        if (e_vld[i] || e_chkres[i]) begin
          chk($sformatf("d%0d resp_result", i), resp_result[i], e_res[i]);
          chk($sformatf("d%0d resp_zero", i), {31'b0, resp_zero[i]}, {31'b0, e_zero[i]});
          chk($sformatf("d%0d resp_err", i), {31'b0, resp_err[i]}, {31'b0, e_err[i]});
        end
      end
    end
  end

  // ---- reference model ----
  function automatic logic [31:0] op_res(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd3: return a - b;
      3'd4: return (a < b) ? 32'd1 : 32'd0;
      3'd5: return p[31:0];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] op_ctrl(input logic [2:0] op);
    case (op)
      3'd0: return 4'b0000;
      3'd1: return 4'b0001;
      3'd3: return 4'b0110;
      3'd4: return 4'b0111;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic int mul_steps(input bit ee, input logic [31:0] b);
    if (!ee) return 32;
    for (int k = 31; k >= 0; k--) if (b[k]) return k + 1;
    return 1;
  endfunction

  // Accumulator before step k holds a * (low k bits of b).
  function automatic logic [31:0] part_acc(input logic [31:0] a, input logic [31:0] b,
                                           input int k);
    logic [63:0] m, p;
    m = 64'(b) & ((64'd1 << k) - 64'd1);
    p = 64'(a) * m;
    return p[31:0];
  endfunction

  task automatic junk_inputs();
    req_op = 3'($urandom_range(0, 7)); req_a = $urandom; req_b = $urandom;
  endtask

  task automatic set_step(input int sel, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int k);
    e_rdy[sel] = 1'b0; e_vld[sel] = 1'b0;
    e_ac[sel] = op_ctrl(op);
    e_aa[sel] = (op == 3'd5) ? part_acc(a, b, k) : a;
    e_ab[sel] = (op == 3'd5) ? (a << k) : b;
  endtask

  // Called just after a clock edge; returns just after the handshake edge.
  task automatic txn(input int sel, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input int stall, input bit junk,
                     output logic [31:0] got, output logic gz, output int nadd);
    int L;
    req_valid[sel] = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid[sel] = junk;
    if (junk) junk_inputs(); else begin req_op = '0; req_a = '0; req_b = '0; end
    L = (op < 3'd5) ? 1 : (op == 3'd5) ? mul_steps(sel == 0, b) : 0;
    nadd = 0;
    for (int k = 0; k < L; k++) begin
      set_step(sel, op, a, b, k);
      if (alu_ctrl[sel] == 4'b0010) nadd++;
      @(posedge clk); #1;
      if (junk) junk_inputs();
    end
    e_rdy[sel] = 1'b0; e_vld[sel] = 1'b1;
    e_res[sel] = op_res(op, a, b); e_zero[sel] = (e_res[sel] == 32'd0);
    e_err[sel] = (op > 3'd5);
    e_aa[sel] = '0; e_ab[sel] = '0; e_ac[sel] = 4'b0000;
    got = resp_result[sel]; gz = resp_zero[sel];
    resp_ready[sel] = (stall == 0);
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1 resp_ready[sel] = 1'b1;
    end
    @(posedge clk); #1;
    resp_ready[sel] = 1'b0; req_valid[sel] = 1'b0;
    req_op = '0; req_a = '0; req_b = '0;
    set_idle(sel);
  endtask

  logic [31:0] got, ra, rb;
  logic        gz;
  int          nadd, rsel;
  logic [2:0]  rop;

  initial begin
    rst = 1'b1; chk_en = 1'b0;
    req_valid = '0; resp_ready = '0; req_op = '0; req_a = '0; req_b = '0;
    for (int i = 0; i < 2; i++) begin
      set_idle(i); e_chkres[i] = 1'b1; e_res[i] = '0; e_zero[i] = 1'b0; e_err[i] = 1'b0;
    end
    @(posedge clk); #1 chk_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    set_idle(0); set_idle(1);
    @(posedge clk); #1;

    txn(0, 3'd2, 32'd5, 32'd7, 0, 1'b0, got, gz, nadd);
    chk("add 5+7", got, 32'd12);
    txn(0, 3'd3, 32'd3, 32'd3, 0, 1'b0, got, gz, nadd);
    chk("sub 3-3", got, 32'd0);
    chk("sub zero", {31'b0, gz}, 32'd1);
    txn(1, 3'd4, 32'd1, 32'hFFFF_FFFF, 0, 1'b0, got, gz, nadd);
    chk("slt unsigned", got, 32'd1);
    txn(0, 3'd5, 32'd6, 32'd7, 0, 1'b0, got, gz, nadd);
    chk("mul 6*7", got, 32'd42);
    chk("mul 6*7 steps", nadd, 32'd3);
    txn(0, 3'd5, 32'd9, 32'd0, 0, 1'b0, got, gz, nadd);
    chk("mul b=0", got, 32'd0);
    chk("mul b=0 steps", nadd, 32'd1);
    chk("mul b=0 zero", {31'b0, gz}, 32'd1);
    txn(1, 3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1, got, gz, nadd);
    chk("mul max", got, 32'd1);
    chk("mul max steps", nadd, 32'd32);
    txn(1, 3'd5, 32'd3, 32'd1, 2, 1'b0, got, gz, nadd);
    chk("mul full steps", nadd, 32'd32);
    txn(0, 3'd7, 32'd4, 32'd4, 0, 1'b1, got, gz, nadd);
    chk("illegal result", got, 32'd0);
    chk("illegal no exec", nadd, 32'd0);
    txn(0, 3'd1, 32'hF0F0_0000, 32'h0000_0F0F, 10, 1'b1, got, gz, nadd);
    chk("or stall", got, 32'hF0F0_0F0F);

    // reset in the middle of a multiply
    req_valid[1] = 1'b1; req_op = 3'd5; req_a = 32'h1234_5677; req_b = 32'h8000_1111;
    @(posedge clk); #1 req_valid[1] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      set_step(1, 3'd5, 32'h1234_5677, 32'h8000_1111, k);
      @(posedge clk); #1;
    end
    set_step(1, 3'd5, 32'h1234_5677, 32'h8000_1111, 10);
    #2 rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_idle(i); e_chkres[i] = 1'b1; e_res[i] = '0; e_zero[i] = 1'b0; e_err[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    set_idle(0); set_idle(1);
    repeat (4) @(posedge clk);
    #1;
    txn(1, 3'd2, 32'd1, 32'd1, 0, 1'b0, got, gz, nadd);
    chk("add after reset", got, 32'd2);

    for (int n = 0; n < 40; n++) begin
      rsel = $urandom_range(0, 1);
      rop  = 3'($urandom_range(0, 7));
      ra   = $urandom;
      rb   = $urandom_range(0, 1) ? ($urandom >> $urandom_range(0, 31)) : $urandom;
      txn(rsel, rop, ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)), got, gz, nadd);
      chk("rand result", got, op_res(rop, ra, rb));
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
